// File: rtl/exp_sequencer_if.sv
// Handshake bundle between the exponentiation sequencer, its requester,
// the external latency down-counter and the modular multiplier.
interface exp_seq_if #(
    parameter int unsigned EXP_W = 64,
    parameter int unsigned CNT_W = 6
);
    // Requester side
    logic             start;
    logic [EXP_W-1:0] exponent;
    logic [CNT_W-1:0] lat;
    logic             busy;
    logic             done;
    logic             zero_exp;

    // Down-counter side
    logic             preset;
    logic [CNT_W-1:0] cnt_in;
    logic             cnt_done;

    // Multiplier side
    logic             mul_start;
    logic             mul_op;

    // Environment that drives requests and owns the counter
    modport master (
        output start, exponent, lat, cnt_done,
        input  preset, cnt_in, mul_start, mul_op, busy, done, zero_exp
    );

    // The sequencer itself
    modport slave (
        input  start, exponent, lat, cnt_done,
        output preset, cnt_in, mul_start, mul_op, busy, done, zero_exp
    );
endinterface

// File: rtl/exp_sequencer.sv
// Left-to-right square-and-multiply sequencer. For each exponent bit from the
// MSB down it issues one square, then one multiply when the bit is set, and
// paces every issue on an external down-counter loaded with the latency.
module exp_sequencer #(
    parameter int unsigned EXP_W = 64,
    parameter int unsigned CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    exp_seq_if.slave   bus
);

    localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR_ISSUE,
        MUL_ISSUE,
        GUARD,
        WAIT,
        FINISH
    } state_t;

    state_t           state_q;
    logic [EXP_W-1:0] exp_q;
    logic [CNT_W-1:0] lat_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic             last_mul_q;
    logic             preset_q;
    logic [CNT_W-1:0] cnt_in_q;
    logic             mul_start_q;
    logic             mul_op_q;
    logic             busy_q;
    logic             done_q;
    logic             zero_exp_q;

    logic [IDX_W-1:0] msb_idx_d;
    logic             exp_zero_d;
    logic             cur_bit_d;

    // Index of the most-significant set bit of the latched exponent
    always_comb begin
        msb_idx_d = '0;
        for (int unsigned i = 0; i < EXP_W; i++) begin
            if (exp_q[i]) begin
                msb_idx_d = IDX_W'(i);
            end
        end
    end

    assign exp_zero_d = (exp_q == '0);
    assign cur_bit_d  = exp_q[bit_idx_q];

    // Sequencer state machine; strobes are registered and default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            lat_q       <= '0;
            bit_idx_q   <= '0;
            last_mul_q  <= 1'b0;
            preset_q    <= 1'b0;
            cnt_in_q    <= '0;
            mul_start_q <= 1'b0;
            mul_op_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_exp_q  <= 1'b0;
        end else begin
            preset_q    <= 1'b0;
            cnt_in_q    <= '0;
            mul_start_q <= 1'b0;
            mul_op_q    <= 1'b0;
            done_q      <= 1'b0;
            zero_exp_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        exp_q   <= bus.exponent;
                        // A zero latency would never let the counter expire
                        lat_q   <= (bus.lat == '0) ? CNT_W'(1) : bus.lat;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end

                SCAN: begin
                    if (exp_zero_d) begin
                        done_q     <= 1'b1;
                        zero_exp_q <= 1'b1;
                        state_q    <= FINISH;
                    end else begin
                        bit_idx_q   <= msb_idx_d;
                        last_mul_q  <= 1'b0;
                        preset_q    <= 1'b1;
                        cnt_in_q    <= lat_q;
                        mul_start_q <= 1'b1;
                        mul_op_q    <= 1'b0;
                        state_q     <= SQR_ISSUE;
                    end
                end

                SQR_ISSUE, MUL_ISSUE: begin
                    state_q <= GUARD;
                end

                // Counter was only just loaded; its expiry flag is stale here
                GUARD: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (bus.cnt_done) begin
                        if (!last_mul_q && cur_bit_d) begin
                            last_mul_q  <= 1'b1;
                            preset_q    <= 1'b1;
                            cnt_in_q    <= lat_q;
                            mul_start_q <= 1'b1;
                            mul_op_q    <= 1'b1;
                            state_q     <= MUL_ISSUE;
                        end else if (bit_idx_q == '0) begin
                            done_q     <= 1'b1;
                            zero_exp_q <= exp_zero_d;
                            state_q    <= FINISH;
                        end else begin
                            bit_idx_q   <= bit_idx_q - IDX_W'(1);
                            last_mul_q  <= 1'b0;
                            preset_q    <= 1'b1;
                            cnt_in_q    <= lat_q;
                            mul_start_q <= 1'b1;
                            mul_op_q    <= 1'b0;
                            state_q     <= SQR_ISSUE;
                        end
                    end
                end

                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.preset    = preset_q;
    assign bus.cnt_in    = cnt_in_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_op    = mul_op_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.zero_exp  = zero_exp_q;

    // Counter load and multiply launch always travel together
    ap_strobe_pair: assert property (@(posedge clk) disable iff (rst)
        preset_q == mul_start_q);

    // Strobes are single-cycle
    ap_strobe_single: assert property (@(posedge clk) disable iff (rst)
        mul_start_q |=> !mul_start_q);

    // Strobes only appear while in an issue state
    ap_strobe_state: assert property (@(posedge clk) disable iff (rst)
        mul_start_q |-> (state_q == SQR_ISSUE || state_q == MUL_ISSUE));

    // Completion is only signalled from FINISH
    ap_done_state: assert property (@(posedge clk) disable iff (rst)
        done_q |-> (state_q == FINISH && busy_q));

endmodule

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer: table vectors, reset-abort and
// busy-restart sequences, then randomized exponents against an op-list model.
module tb_exp_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_seq_if #(.EXP_W(64), .CNT_W(6)) ifc ();

    exp_sequencer #(.EXP_W(64), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Down-counter model: expires lat cycles after its load cycle
    logic [5:0] rem_q = '0;
    logic       force_done = 1'b0;

    always @(posedge clk) begin
        if (ifc.preset === 1'b1) rem_q <= ifc.cnt_in;
        else if (rem_q != 6'd0)  rem_q <= rem_q - 6'd1;
    end

    assign ifc.cnt_done = (rem_q == 6'd0) | force_done;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // One complete transaction, checked against the square-and-multiply op list
    task automatic run_txn(input logic [63:0] e, input logic [5:0] l,
                           input bit noise, input bit restart,
                           output int n_ops, output logic [127:0] ops_seen,
                           output logic zero_seen);
        int           m_n;
        logic [127:0] m_ops;
        bit           found;
        int           lat_eff;
        int           exp_done;
        int           cyc;
        int           last_iss;
        int           proto_err;
        bit           prev_ms;
        bit           done_seen;
        int           done_cyc;

        m_n   = 0;
        m_ops = '0;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (e[i]) found = 1'b1;
            if (found) begin
                m_ops[m_n] = 1'b0;
                m_n++;
                if (e[i]) begin
                    m_ops[m_n] = 1'b1;
                    m_n++;
                end
            end
        end
        lat_eff  = (l == 6'd0) ? 1 : int'(l);
        exp_done = 2 + m_n * (lat_eff + 2);

        n_ops = 0; ops_seen = '0; zero_seen = 1'b0;
        cyc = 0; last_iss = -10; proto_err = 0; prev_ms = 1'b0;
        done_seen = 1'b0; done_cyc = -1;

        ifc.start    = 1'b1;
        ifc.exponent = e;
        ifc.lat      = l;

        while (!done_seen && cyc < exp_done + 50) begin
            @(negedge clk);
            cyc++;
            if (ifc.preset !== ifc.mul_start) proto_err++;
            if (ifc.busy !== 1'b1) proto_err++;
            if (ifc.mul_start === 1'b1) begin
                if (prev_ms) proto_err++;
                if (cyc - last_iss < 3) proto_err++;
                if (ifc.cnt_in !== 6'(lat_eff)) proto_err++;
                if (n_ops < 128) ops_seen[n_ops] = ifc.mul_op;
                n_ops++;
                last_iss = cyc;
            end
            if (ifc.done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                zero_seen = ifc.zero_exp;
            end
            // Hold the expiry flag high across ISSUE and GUARD when asked
            force_done = noise && ((ifc.mul_start === 1'b1) || prev_ms);
            prev_ms    = (ifc.mul_start === 1'b1);
            if (restart && ifc.busy === 1'b1 && $urandom_range(0, 3) == 0) begin
                ifc.start    = 1'b1;
                ifc.exponent = {$urandom, $urandom};
                ifc.lat      = 6'($urandom_range(0, 63));
            end else begin
                ifc.start = 1'b0;
            end
        end

        chk("done_seen", 128'(done_seen), 128'(1));
        chk("latency",   128'(done_cyc),  128'(exp_done));
        chk("op_count",  128'(n_ops),     128'(m_n));
        chk("op_order",  ops_seen,        m_ops);
        chk("zero_exp",  128'(zero_seen), 128'(e == 64'd0));
        chk("protocol",  128'(proto_err), 128'(0));

        @(negedge clk);
        chk("idle_after", 128'({ifc.busy, ifc.done, ifc.mul_start, ifc.preset}), 128'(0));
        ifc.start  = 1'b0;
        force_done = 1'b0;
    endtask

    typedef struct {
        logic [63:0] e;
        logic [5:0]  l;
        int          nops;
        logic [7:0]  ops_lo;
        logic        zero;
        bit          noise;
        bit          restart;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int           n;
        logic [127:0] ops;
        logic         z;
        int           seen_ms;

        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [127:0] ops;
        logic         z;
        int           seen_ms;
        int           w;
        logic [63:0]  e;
        logic [63:0]  mask;

        tbl[0] = '{64'hB,                  6'd3,  7,   8'h52, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'h0,                  6'd3,  0,   8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{64'h1,                  6'd0,  2,   8'h02, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 128, 8'hAA, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{64'h2,                  6'd2,  3,   8'h02, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{64'h5,                  6'd1,  5,   8'h12, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{64'hB,                  6'd3,  7,   8'h52, 1'b0, 1'b1, 1'b1};
        tbl[7] = '{64'h8000_0000_0000_0000, 6'd1, 65,  8'h02, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{64'h3,                  6'd63, 4,   8'h0A, 1'b0, 1'b1, 1'b0};

        ifc.start    = 1'b0;
        ifc.exponent = '0;
        ifc.lat      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 128'({ifc.preset, ifc.cnt_in, ifc.mul_start, ifc.mul_op,
                                   ifc.busy, ifc.done, ifc.zero_exp}), 128'(0));
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].e, tbl[i].l, tbl[i].noise, tbl[i].restart, n, ops, z);
            chk("tbl_nops", 128'(n),        128'(tbl[i].nops));
            chk("tbl_ops",  128'(ops[7:0]), 128'(tbl[i].ops_lo));
            chk("tbl_zero", 128'(z),        128'(tbl[i].zero));
        end

        // Reset pulsed during the third WAIT aborts without done or strobes
        ifc.start    = 1'b1;
        ifc.exponent = 64'hB;
        ifc.lat      = 6'd3;
        seen_ms      = 0;
        for (int c = 0; c < 100 && seen_ms < 3; c++) begin
            @(negedge clk);
            ifc.start = 1'b0;
            if (ifc.mul_start === 1'b1) seen_ms++;
        end
        chk("abort_reach_third", 128'(seen_ms), 128'(3));
        repeat (2) @(negedge clk);
        chk("abort_in_wait", 128'({ifc.busy, ifc.mul_start, ifc.done}), 128'(3'b100));
        rst = 1'b1;
        #1;
        chk("abort_async_clear", 128'({ifc.preset, ifc.cnt_in, ifc.mul_start, ifc.mul_op,
                                       ifc.busy, ifc.done, ifc.zero_exp}), 128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_held", 128'({ifc.preset, ifc.cnt_in, ifc.mul_start, ifc.mul_op,
                                    ifc.busy, ifc.done, ifc.zero_exp}), 128'(0));
        end
        rst = 1'b0;
        run_txn(64'h2, 6'd2, 1'b0, 1'b0, n, ops, z);
        chk("abort_restart_ops", 128'(ops[7:0]), 128'(8'h02));
        chk("abort_restart_n",   128'(n),        128'(3));

        // Randomized exponents of varying width, with noise and restarts
        for (int i = 0; i < 30; i++) begin
            w    = $urandom_range(1, 20);
            mask = (64'd1 << w) - 64'd1;
            e    = {$urandom, $urandom} & mask;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(e, 6'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), n, ops, z);
        end
        run_txn({$urandom, $urandom}, 6'd0, 1'b1, 1'b1, n, ops, z);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
